// File: rtl/bus_sequencer.sv
// rtl/bus_sequencer.sv - tristate register bus initiator: request FIFO plus DRIVE/LATCH strobe sequencer
// Optional turnaround cycle between transfers is enabled by defining E800_BUS_TURNAROUND_EN.
module bus_sequencer #(
    parameter int c_regs      = 4,
    parameter int c_sel_width = 2,
    parameter int c_depth     = 4
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_req_valid,
    output logic                   o_req_ready,
    input  logic [c_sel_width-1:0] i_req_src,
    input  logic [c_sel_width-1:0] i_req_dst,
    output logic [c_regs-1:0]      o_enable_out,
    output logic [c_regs-1:0]      o_enable_in,
    output logic                   o_done,
    output logic                   o_error,
    output logic                   o_busy
);

    localparam int AW = (c_depth > 1) ? $clog2(c_depth) : 1;
    localparam int EW = 2 * c_sel_width;
    localparam logic [AW:0]            DEPTH   = (AW + 1)'(c_depth);
    localparam logic [AW:0]            CNT_ONE = (AW + 1)'(1);
    localparam logic [AW-1:0]          PTR_ONE = AW'(1);
    localparam logic [c_sel_width:0]   REGS    = (c_sel_width + 1)'(c_regs);

`ifdef E800_BUS_TURNAROUND_EN
    typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_LATCH, S_GAP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_LATCH} state_t;
`endif

    state_t state_q, state_d;

    logic [EW-1:0]          mem_q [c_depth];
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [AW:0]            count_q, count_d;

    logic [c_sel_width-1:0] src_q, src_d;
    logic [c_sel_width-1:0] dst_q, dst_d;
    logic [c_regs-1:0]      enable_out_q, enable_out_d;
    logic [c_regs-1:0]      enable_in_q, enable_in_d;
    logic                   done_q, done_d;
    logic                   error_q, error_d;
    logic                   busy_q, busy_d;
    logic                   ready_q, ready_d;

    logic                   push;
    logic                   pop;
    logic                   launch;
    logic                   empty;
    logic [EW-1:0]          head;
    logic [c_sel_width-1:0] head_src;
    logic [c_sel_width-1:0] head_dst;
    logic                   head_legal;

    assign push     = i_req_valid && ready_q;
    assign empty    = (count_q == '0);
    assign head     = mem_q[rd_ptr_q];
    assign head_src = head[EW-1:c_sel_width];
    assign head_dst = head[c_sel_width-1:0];
    assign head_legal = (head_src != head_dst)
                     && ({1'b0, head_src} < REGS)
                     && ({1'b0, head_dst} < REGS);

    always_ff @(posedge i_clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {i_req_src, i_req_dst};
        end
    end

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        done_d  = 1'b0;
        error_d = 1'b0;
        pop     = 1'b0;
        launch  = 1'b0;

        case (state_q)
            S_IDLE:  launch = 1'b1;
            S_DRIVE: state_d = S_LATCH;
            S_LATCH: begin
                done_d = 1'b1;
`ifdef E800_BUS_TURNAROUND_EN
                state_d = S_GAP;
`else
                // Without turnaround the next transfer's drive strobe replaces this one on the same edge.
                state_d = S_IDLE;
                launch  = 1'b1;
`endif
            end
`ifdef E800_BUS_TURNAROUND_EN
            S_GAP: begin
                state_d = S_IDLE;
                launch  = 1'b1;
            end
`endif
            default: state_d = S_IDLE;
        endcase

        // An illegal head is dropped in a single cycle and flagged; it never reaches the strobes.
        if (launch && !empty) begin
            pop = 1'b1;
            if (head_legal) begin
                state_d = S_DRIVE;
                src_d   = head_src;
                dst_d   = head_dst;
            end else begin
                state_d = S_IDLE;
                error_d = 1'b1;
            end
        end

        for (int k = 0; k < c_regs; k++) begin
            enable_out_d[k] = ((state_d == S_DRIVE) || (state_d == S_LATCH))
                           && (src_d == c_sel_width'(k));
            enable_in_d[k]  = (state_d == S_LATCH) && (dst_d == c_sel_width'(k));
        end

        wr_ptr_d = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d = pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_ONE;
        end else if (!push && pop) begin
            count_d = count_q - CNT_ONE;
        end

        busy_d  = (count_d != '0) || (state_d != S_IDLE);
        ready_d = (count_d != DEPTH);
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            src_q        <= '0;
            dst_q        <= '0;
            enable_out_q <= '0;
            enable_in_q  <= '0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            busy_q       <= 1'b0;
            ready_q      <= 1'b1;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            src_q        <= src_d;
            dst_q        <= dst_d;
            enable_out_q <= enable_out_d;
            enable_in_q  <= enable_in_d;
            done_q       <= done_d;
            error_q      <= error_d;
            busy_q       <= busy_d;
            ready_q      <= ready_d;
        end
    end

    assign o_enable_out = enable_out_q;
    assign o_enable_in  = enable_in_q;
    assign o_done       = done_q;
    assign o_error      = error_q;
    assign o_busy       = busy_q;
    assign o_req_ready  = ready_q;

endmodule

// File: doc/bus_sequencer.md
# bus_sequencer

Initiator side of the shared tristate register bus. Accepts queued transfer requests (source register → destination register) and generates the one-hot `enable_out` / `enable_in` strobes that the bus registers respond to. It guarantees at most one driver on the bus at any time and a one-cycle settle window before the destination captures.

## Interface

**Parameters**
- `c_regs`, default 4: number of bus registers served. Sets the width of both strobe vectors.
- `c_sel_width`, default 2: width of register indices. Must satisfy 2^c_sel_width ≥ c_regs.
- `c_depth`, default 4: request FIFO depth. Power of 2, ≥ 2.

**Ports**
- `i_clock`, input, 1: sole clock. All state updates on the rising edge.
- `i_reset`, input, 1: asynchronous, active-high reset.
- `i_req_valid`, input, 1: request present on `i_req_src` / `i_req_dst`.
- `o_req_ready`, output, 1: FIFO not full.
- `i_req_src`, input, c_sel_width: index of the register that drives the bus.
- `i_req_dst`, input, c_sel_width: index of the register that captures the bus.
- `o_enable_out`, output, c_regs: one-hot or zero. Drive strobe, bit k goes to register k.
- `o_enable_in`, output, c_regs: one-hot or zero. Capture strobe, bit k goes to register k.
- `o_done`, output, 1: one-cycle pulse after each completed transfer.
- `o_error`, output, 1: one-cycle pulse when an illegal request is discarded.
- `o_busy`, output, 1: high when the FIFO is non-empty or the FSM is not in IDLE.

## Operation
- **Accept:** a request is accepted on a rising edge where `i_req_valid && o_req_ready`. It is written to a c_depth-entry FIFO holding {src, dst}.
  - `o_req_ready` is low when the FIFO is full. A request offered while full is not accepted, and the requester must hold it.
  - Push and pop on the same edge are both performed.
- **FSM states:** IDLE, DRIVE, LATCH, GAP.
- **IDLE:**
  - If the FIFO is empty, stay in IDLE.
  - If the FIFO is non-empty, pop the head entry.
  - Legal entry (src ≠ dst, src < c_regs, dst < c_regs): go to DRIVE.
  - Illegal entry: stay in IDLE and pulse `o_error` for the next cycle. No strobes are asserted for it.
- **DRIVE:** `o_enable_out[src]` = 1, `o_enable_in` = 0. The bus settles. Next state is LATCH.
- **LATCH:** `o_enable_out[src]` = 1, `o_enable_in[dst]` = 1. The destination captures on the edge that ends LATCH. Next state is GAP, and `o_done` pulses for one cycle.
- **GAP:** all strobes are 0 (bus turnaround).
  - FIFO non-empty: pop and go to DRIVE, or stay in IDLE-equivalent handling with `o_error` if the entry is illegal.
  - FIFO empty: go to IDLE.
- **Outputs:** all outputs are registered (Moore). Strobes never carry more than one bit set.
- **Reset (asynchronous, takes effect immediately, including mid-transfer):**
  - FSM goes to IDLE and the FIFO is emptied.
  - `o_enable_out` = 0, `o_enable_in` = 0, `o_done` = 0, `o_error` = 0, `o_busy` = 0.
  - `o_req_ready` = 1.
  - The interrupted transfer is lost.

## Timing
- Request accepted at edge E0.
- E1: pop, enter DRIVE. Source strobe high in cycle E1–E2.
- E2: enter LATCH. Destination strobe high in cycle E2–E3.
- E3: destination register loads the data. Strobes fall, and `o_done` is high in cycle E3–E4.
- Turnaround enabled: a queued next request pops at E4, and its source strobe is high from E4. Throughput is one transfer per 3 cycles.
- An illegal request consumes one cycle. `o_error` is high in the cycle after its pop.
- `o_busy` rises the cycle after the first accept. It falls in the cycle after the last strobe-low edge with the FIFO empty.

## Configuration
- Macro: `E800_BUS_TURNAROUND_EN`.
- **Defined:** GAP state is present, giving one all-zero cycle between consecutive transfers (3 cycles per transfer).
- **Undefined:** GAP is removed.
  - LATCH with the FIFO non-empty pops and goes directly to DRIVE on the same edge. The old strobes fall and the new `o_enable_out` rises on that single edge.
  - LATCH with the FIFO empty goes to IDLE.
  - Throughput is one transfer per 2 cycles.
  - `o_done` timing is unchanged.

## Test plan
- **Single transfer:** reg 1 preloaded 8'hBD, request src=1 dst=0 → after 3 edges reg 0 = 8'hBD. `o_done` pulses once. Strobes are never both high on different-index drivers.
- **Back-to-back:** 3 requests (1→0, 0→2, 2→3) pushed on consecutive edges, reg 1 = 8'h5A → all of reg 0, 2, 3 = 8'h5A.
  - 3 `o_done` pulses.
  - 3 cycles apart with `E800_BUS_TURNAROUND_EN`, 2 cycles apart without it.
- **FIFO full:** 5 requests with c_depth=4 and FSM stalled at start → `o_req_ready` low after the 4th accept. The 5th request is accepted only after the first pop, and all 5 complete in order.
- **Illegal requests:** src=dst=2, then dst=3 with c_regs=3 → 2 `o_error` pulses, no strobes, no `o_done`. A following legal request completes normally.
- **Reset in LATCH:** assert `i_reset` mid-cycle → strobes drop to 0 before the next edge, `o_busy` = 0, FIFO empty, `o_req_ready` = 1. The destination register is unchanged.
- **Mutual exclusion:** random legal traffic for 1000 cycles → popcount(`o_enable_out`) ≤ 1 and popcount(`o_enable_in`) ≤ 1 every cycle. A bus scoreboard matches every capture.
